// File: rtl/muldiv_ctrl.sv
// Sequencer between the EX stage and an iterative multiply/divide unit.
// Resolves divide special cases and repeated requests locally; otherwise runs the unit with timeout/flush abort.
module muldiv_ctrl #(
    parameter logic [5:0] TIMEOUT = 6'd40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        mul_or_div_i,
    input  logic        sign1_i,
    input  logic        sign2_i,
    input  logic [31:0] op1_i,
    input  logic [31:0] op2_i,
    input  logic        flush_i,
    output logic        md_start_o,
    output logic        md_mul_or_div_o,
    output logic        md_sign1_o,
    output logic        md_sign2_o,
    output logic [31:0] md_op1_o,
    output logic [31:0] md_op2_o,
    output logic        md_cancel_o,
    input  logic [63:0] md_result_i,
    input  logic        md_done_i,
    output logic [63:0] result_o,
    output logic        done_o,
    output logic        err_o,
    output logic        stall_req_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [31:0] req_op1, req_op2;
    logic        req_div, req_s1, req_s2;
    logic [5:0]  cnt;

    logic        cache_vld;
    logic [31:0] cache_op1, cache_op2;
    logic        cache_div, cache_s1, cache_s2;
    logic [63:0] cache_res;

    logic        accept;
    logic        special;
    logic [63:0] special_res;
    logic        cache_hit;
    logic        busy_done;
    logic        busy_tmo;

    assign accept    = (state == IDLE) && start_i && !flush_i;
    assign busy_done = (state == BUSY) && !flush_i && md_done_i;
    // md_done_i in the same cycle as the timeout still counts as a completion
    assign busy_tmo  = (state == BUSY) && !flush_i && !md_done_i && (cnt == TIMEOUT);

    assign cache_hit = cache_vld
                    && (cache_op1 == op1_i) && (cache_op2 == op2_i)
                    && (cache_div == mul_or_div_i)
                    && (cache_s1 == sign1_i) && (cache_s2 == sign2_i);

    always_comb begin
        special     = 1'b0;
        special_res = 64'd0;
        if (mul_or_div_i && (op2_i == 32'd0)) begin
            special     = 1'b1;
            special_res = {32'hFFFF_FFFF, op1_i};
        end else if (mul_or_div_i && sign1_i && sign2_i &&
                     (op1_i == 32'h8000_0000) && (op2_i == 32'hFFFF_FFFF)) begin
            special     = 1'b1;
            special_res = {32'h8000_0000, 32'h0000_0000};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        md_start_o      = 1'b0;
        md_mul_or_div_o = 1'b0;
        md_sign1_o      = 1'b0;
        md_sign2_o      = 1'b0;
        md_op1_o        = 32'd0;
        md_op2_o        = 32'd0;
        md_cancel_o     = 1'b0;
        done_o          = 1'b0;
        stall_req_o     = 1'b0;
        case (state)
            IDLE: begin
                stall_req_o = start_i && !flush_i;
                if (accept) begin
                    state_nxt = (special || cache_hit) ? DONE : BUSY;
                end
            end
            BUSY: begin
                stall_req_o     = !flush_i;
                md_start_o      = (cnt == 6'd0);
                md_mul_or_div_o = req_div;
                md_sign1_o      = req_s1;
                md_sign2_o      = req_s2;
                md_op1_o        = req_op1;
                md_op2_o        = req_op2;
                md_cancel_o     = flush_i || busy_tmo;
                if (flush_i) begin
                    state_nxt = IDLE;
                end else if (busy_done || busy_tmo) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done_o    = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        // keep the stall request low while reset is held, even with start_i asserted
        if (!rst) begin
            stall_req_o = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_op1   <= 32'd0;
            req_op2   <= 32'd0;
            req_div   <= 1'b0;
            req_s1    <= 1'b0;
            req_s2    <= 1'b0;
            cnt       <= 6'd0;
            result_o  <= 64'd0;
            err_o     <= 1'b0;
            cache_vld <= 1'b0;
            cache_op1 <= 32'd0;
            cache_op2 <= 32'd0;
            cache_div <= 1'b0;
            cache_s1  <= 1'b0;
            cache_s2  <= 1'b0;
            cache_res <= 64'd0;
        end else begin
            if (accept) begin
                req_op1 <= op1_i;
                req_op2 <= op2_i;
                req_div <= mul_or_div_i;
                req_s1  <= sign1_i;
                req_s2  <= sign2_i;
                cnt     <= 6'd0;
                err_o   <= 1'b0;
                if (special) begin
                    result_o <= special_res;
                end else if (cache_hit) begin
                    result_o <= cache_res;
                end
            end else if (state == BUSY) begin
                cnt <= cnt + 6'd1;
            end

            if (busy_done) begin
                result_o  <= md_result_i;
                cache_vld <= 1'b1;
                cache_op1 <= req_op1;
                cache_op2 <= req_op2;
                cache_div <= req_div;
                cache_s1  <= req_s1;
                cache_s2  <= req_s2;
                cache_res <= md_result_i;
            end

            if (busy_tmo) begin
                result_o <= 64'd0;
                err_o    <= 1'b1;
            end
        end
    end

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 6'd40: maximum BUSY cycles allowed for the mul/div unit before abort.
REQ-002 SHALL have one clock; reset is asynchronous and active-low; ports: clk in 1 (all state on rising edge); rst in 1 (async, active-low).
REQ-003 SHALL have start_i in 1: level request from the EX stage, held while the instruction sits in EX.
REQ-004 SHALL have mul_or_div_i in 1 (0=MUL, 1=DIV), sign1_i in 1, sign2_i in 1 (1=Signed), op1_i in 32, op2_i in 32: request operands.
REQ-005 SHALL have flush_i in 1: interrupt/branch flush of the EX instruction.
REQ-006 SHALL have md_start_o out 1, md_mul_or_div_o out 1, md_sign1_o out 1, md_sign2_o out 1, md_op1_o out 32, md_op2_o out 32, md_cancel_o out 1: unit command side.
REQ-007 SHALL have md_result_i in 64, md_done_i in 1: unit response side.
REQ-008 SHALL have result_o out 64, done_o out 1, err_o out 1, stall_req_o out 1: EX/pipeline side.
REQ-009 SHALL use result layout {hi, lo} for MUL and {quotient, remainder} for DIV.

Function
REQ-010 SHALL implement states IDLE, BUSY, DONE.
REQ-011 IDLE: SHALL accept when start_i=1 and flush_i=0, latching op1, op2, mul_or_div and signs into a request register.
REQ-012 On accept, SHALL go to DONE (no unit start) on a special case: DIV with op2=0 gives {32'hFFFFFFFF, op1}; signed DIV with op1=32'h80000000 and op2=32'hFFFFFFFF gives {32'h80000000, 32'h0}.
REQ-013 On accept, SHALL go to DONE (no unit start) on a cache hit: cache valid and all five latched fields equal the incoming request; result is the cached 64-bit value.
REQ-014 Otherwise SHALL go to BUSY.
REQ-015 md_start_o SHALL be a one-cycle pulse in the first BUSY cycle only.
REQ-016 md_op*/md_sign*/md_mul_or_div_o SHALL drive from the request register while BUSY and be 0 otherwise.
REQ-017 BUSY: on md_done_i=1, SHALL capture md_result_i into result_o, write the cache (fields plus result, valid=1), and go to DONE.
REQ-018 BUSY cycle counter SHALL be 6 bits, cleared on accept; when it reaches TIMEOUT without md_done_i, SHALL pulse md_cancel_o, set result_o=0 and err_o=1, go to DONE, and leave the cache unchanged.
REQ-019 DONE: done_o=1 for exactly one cycle, then IDLE.
REQ-020 start_i SHALL be ignored in DONE, since it is the same instruction.
REQ-021 result_o and err_o SHALL hold until the next accept; err_o SHALL clear on accept.
REQ-022 stall_req_o SHALL equal (IDLE & start_i & ~flush_i) | (BUSY & ~flush_i); it is 0 in DONE.
REQ-023 Latency: special/hit gives done_o 1 cycle after accept; unit path gives done_o 1 cycle after md_done_i.
REQ-024 flush_i in BUSY SHALL pulse md_cancel_o in the same cycle, return to IDLE with no done_o, discard the result, and leave the cache unchanged; flush_i wins over a simultaneous md_done_i.
REQ-025 flush_i with start_i in IDLE SHALL NOT accept.
REQ-026 flush_i in DONE SHALL have no effect.
REQ-027 md_done_i outside BUSY SHALL be ignored.

Reset
REQ-028 Asserting rst low SHALL immediately force IDLE and clear: counter, request register, cache valid, result_o, done_o, err_o, md_start_o, md_cancel_o, stall_req_o.
REQ-029 Reset mid-BUSY SHALL NOT pulse md_cancel_o; the unit is reset by the same rst.
REQ-030 The first active edge after rst deasserts SHALL behave as IDLE.

Verification
REQ-031 Scenario 1: DIV signed 100 / -7, unit returns done after 33 cycles -> md_start_o exactly one pulse; stall_req_o high from accept until md_done_i; result_o={FFFFFFF2, 00000002}; done_o one cycle.
REQ-032 Scenario 2: DIVU 5 / 0 -> no md_start_o; done_o one cycle after accept; result_o={FFFFFFFF, 00000005}.
REQ-033 Scenario 3: signed DIV 80000000 / FFFFFFFF -> bypass; result_o={80000000, 00000000}.
REQ-034 Scenario 4: DIV 100/7 completes, then REM 100/7 with identical fields -> second request gives no md_start_o, done_o 1 cycle after accept, same 64-bit result.
REQ-035 Scenario 5: MUL started, flush_i asserted in BUSY cycle 3, same cycle as md_done_i -> md_cancel_o pulse; no done_o; IDLE next cycle; a following identical request misses the cache.
REQ-036 Scenario 6: unit never asserts done, TIMEOUT=40 -> md_cancel_o at BUSY count 40; done_o with err_o=1, result_o=0; rst low mid-BUSY in a rerun -> all outputs 0 immediately.
